tt_sweep_sequencer: RTL

//  Upstream stimulus/capture stage for the combinational gate-level blocks
//  (e.g. the 3-input NOR-only minimal circuit). Sweeps all 2^N_IN input combinations

---
 rtl/tt_sweep_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/tt_sweep_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_sweep_sequencer
//  Description : Sweeps every input combination onto a combinational block,
//                captures its response into a truth table, checks vs expected.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_sequencer #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 10,
    localparam int TW         = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TW-1:0]   exp_tt,
    input  logic            z_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   tt_out,
    output logic            pass,
    output logic [N_IN-1:0] mismatch_idx
);

    // HOLD_CYCLES=1 would give a zero-width counter; keep at least one bit.
    localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            cnt     <= '0;
            exp_q   <= '0;
            tt_out  <= '0;
            vec_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        exp_q   <= exp_tt;
                        tt_out  <= '0;
                        idx     <= '0;
                        cnt     <= '0;
                        vec_out <= '0;
                        busy    <= 1'b1;
                        state   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // Abort wins over a sample/advance falling on the same edge.
                    if (abort) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        vec_out <= '0;
                        idx     <= '0;
                        cnt     <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        tt_out[idx] <= z_in;
                        cnt         <= '0;
                        if (idx == IDX_LAST) begin
                            state   <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vec_out <= '0;
                        end else begin
                            idx     <= idx + 1'b1;
                            vec_out <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign diff = tt_out ^ exp_q;
    assign pass = (diff == '0);

    // Descending scan so the lowest differing index is the one that sticks.
    always_comb begin
        mismatch_idx = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (diff[i]) begin
                mismatch_idx = N_IN'(i);
            end
        end
    end

endmodule
`default_nettype wire
